// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-cold column drive, single-key
// detection with ghost rejection and hold-until-release tracking.
module keypad_scanner #(
  parameter int SCAN_DIV = 2400
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_pressed
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  typedef enum logic {
    SCAN,
    HOLD
  } state_t;

  state_t     state;
  logic [3:0] row_meta;
  logic [3:0] row_sync;
  logic [CW-1:0] cnt;
  logic [1:0] col_idx;
  logic [1:0] act_row;

  logic       dwell_end;
  logic [3:0] low;
  logic       one_low;
  logic [1:0] low_idx;
  logic [1:0] nxt_idx;
  logic       rec_high;

  function automatic logic [3:0] key_map(
    input logic [1:0] r,
    input logic [1:0] c
  );
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hA;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hB;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hC;
      4'hC: k = 4'hE;
      4'hD: k = 4'h0;
      4'hE: k = 4'hF;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  function automatic logic [3:0] col_of(
    input logic [1:0] idx
  );
    return ~(4'b0001 << idx);
  endfunction

  always_comb begin
    dwell_end = (cnt == LAST);
    low       = ~row_sync;
    one_low   = (low != 4'd0) &&
                ((low & (low - 4'd1)) == 4'd0);
    nxt_idx   = col_idx + 2'd1;
    rec_high  = row_sync[act_row];
    low_idx   = 2'd0;
    case (1'b1)
      low[0]:  low_idx = 2'd0;
      low[1]:  low_idx = 2'd1;
      low[2]:  low_idx = 2'd2;
      low[3]:  low_idx = 2'd3;
      default: low_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SCAN;
      row_meta    <= 4'b1111;
      row_sync    <= 4'b1111;
      cnt         <= '0;
      col_idx     <= 2'd0;
      col         <= 4'b1110;
      act_row     <= 2'd0;
      key_code    <= 4'd0;
      key_pressed <= 1'b0;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
      cnt      <= dwell_end ? '0 : cnt + 1'b1;
      unique case (state)
        SCAN: begin
          if (dwell_end) begin
            if (one_low) begin
              key_code    <= key_map(low_idx, col_idx);
              key_pressed <= 1'b1;
              act_row     <= low_idx;
              state       <= HOLD;
            end else begin
              col_idx <= nxt_idx;
              col     <= col_of(nxt_idx);
            end
          end
        end
        HOLD: begin
          // Only the latched row matters; no rollover.
          if (dwell_end && rec_high) begin
            key_pressed <= 1'b0;
            col_idx     <= nxt_idx;
            col         <= col_of(nxt_idx);
            state       <= SCAN;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4
// and a behavioural keypad matrix model.
module tb_keypad_scanner;

  logic       clk;
  logic       reset;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_pressed;
  logic [15:0] keys;

  int tests;
  int fails;
  int n;
  logic seen_c1;

  keypad_scanner #(.SCAN_DIV(4)) dut (
    .clk(clk),
    .reset(reset),
    .row(row),
    .col(col),
    .key_code(key_code),
    .key_pressed(key_pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c])
          row[r] = 1'b0;
  end

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_kp(
    input logic want,
    input int   max
  );
    n = 0;
    while (key_pressed !== want && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    keys  = 16'd0;
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    chk("rst_col", {4'd0, col}, 8'h0E);
    chk("rst_kp", {7'd0, key_pressed}, 8'h00);
    chk("rst_code", {4'd0, key_code}, 8'h00);
    cyc(4);
    chk("scan_c1", {4'd0, col}, 8'h0D);
    cyc(4);
    chk("scan_c2", {4'd0, col}, 8'h0B);
    cyc(4);
    chk("scan_c3", {4'd0, col}, 8'h07);
    cyc(4);
    chk("scan_c0", {4'd0, col}, 8'h0E);

    keys[1*4+2] = 1'b1;
    wait_kp(1'b1, 18);
    chk("k6_kp", {7'd0, key_pressed}, 8'h01);
    chk("k6_code", {4'd0, key_code}, 8'h06);
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk("k6_colhold", {4'd0, col}, 8'h0B);
    end
    chk("k6_kp_held", {7'd0, key_pressed}, 8'h01);

    keys[1*4+2] = 1'b0;
    wait_kp(1'b0, 6);
    chk("rel6_kp", {7'd0, key_pressed}, 8'h00);
    chk("rel6_code", {4'd0, key_code}, 8'h06);
    chk("rel6_col", {4'd0, col}, 8'h07);

    keys[0*4+1] = 1'b1;
    keys[2*4+1] = 1'b1;
    seen_c1 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      cyc(1);
      if (col == 4'b1101) seen_c1 = 1'b1;
      chk("ghost_kp", {7'd0, key_pressed}, 8'h00);
    end
    chk("ghost_cycled", {7'd0, seen_c1}, 8'h01);

    keys = 16'd0;
    keys[3*4+3] = 1'b1;
    wait_kp(1'b1, 40);
    chk("kD_kp", {7'd0, key_pressed}, 8'h01);
    chk("kD_code", {4'd0, key_code}, 8'h0D);
    chk("kD_col", {4'd0, col}, 8'h07);
    keys[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("roll_kp", {7'd0, key_pressed}, 8'h01);
      chk("roll_code", {4'd0, key_code}, 8'h0D);
    end
    keys[3*4+3] = 1'b0;
    wait_kp(1'b0, 6);
    chk("relD_kp", {7'd0, key_pressed}, 8'h00);
    chk("relD_code", {4'd0, key_code}, 8'h0D);
    chk("relD_col", {4'd0, col}, 8'h0E);

    wait_kp(1'b1, 40);
    chk("k1_kp", {7'd0, key_pressed}, 8'h01);
    chk("k1_code", {4'd0, key_code}, 8'h01);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("hrst_kp", {7'd0, key_pressed}, 8'h00);
    chk("hrst_code", {4'd0, key_code}, 8'h00);
    chk("hrst_col", {4'd0, col}, 8'h0E);
    keys = 16'd0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
